// File: rtl/gps_counter_pkg.sv
// Shared encodings and default widths for the GPS-disciplined gate counter.
package gps_counter_pkg;

    typedef enum logic {
        SYNC_WAIT = 1'b0,
        GATE      = 1'b1
    } state_e;

    localparam int DEF_CNT_W  = 32;
    localparam int DEF_GATE_W = 5;

endpackage

// File: rtl/pps_edge_sync.sv
// PPS synchroniser chain with a registered rising-edge pulse.
module pps_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pps_i,
    output logic pps_edge_o
);

    // Top bit of the chain is the previous synchronised sample.
    logic [SYNC_STAGES:0] sync_q;
    logic                 edge_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-1:0], pps_i};
            edge_q <= sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
        end
    end

    assign pps_edge_o = edge_q;

endmodule

// File: rtl/gps_gate_counter.sv
// GPS-gated frequency counter with result handshake.
// Optional missing-PPS watchdog enabled by defining PPS_WATCHDOG_EN.
module gps_gate_counter
    import gps_counter_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter int GATE_W         = DEF_GATE_W,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 110000000
) (
    input  logic              system_clk,
    input  logic              system_rst_n,
    input  logic              pps_in,
    input  logic              enable,
    input  logic [GATE_W-1:0] gate_len,
    output logic [CNT_W-1:0]  result_count,
    output logic [GATE_W-1:0] result_gates,
    output logic              result_saturated,
    output logic              result_valid,
    input  logic              result_ack,
    output logic              result_overrun,
    output logic              pps_lost,
    output logic              pps_edge
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sat_q, sat_d;
    logic [GATE_W-1:0] gcnt_q, gcnt_d;
    logic [GATE_W-1:0] len_q, len_d;
    logic [CNT_W-1:0]  rcnt_q, rcnt_d;
    logic [GATE_W-1:0] rgates_q, rgates_d;
    logic              rsat_q, rsat_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic              new_res;
    logic              timeout;

    pps_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i     (system_clk),
        .rst_ni    (system_rst_n),
        .pps_i     (pps_in),
        .pps_edge_o(pps_edge)
    );

`ifdef PPS_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q;
    logic            lost_q;

    // Counts cycles since the last edge while a gate is open.
    assign timeout = (state_q == GATE) && enable && !pps_edge
                     && (wd_q == WD_LAST);

    always_ff @(posedge system_clk) begin
        if (!system_rst_n) begin
            wd_q   <= '0;
            lost_q <= 1'b0;
        end else begin
            if (pps_edge || state_q != GATE) wd_q <= '0;
            else                             wd_q <= wd_q + WD_W'(1);
            if (pps_edge)     lost_q <= 1'b0;
            else if (timeout) lost_q <= 1'b1;
        end
    end

    assign pps_lost = lost_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
    assign pps_lost       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        gcnt_d  = gcnt_q;
        len_d   = len_q;
        new_res = 1'b0;
        if (!enable) begin
            state_d = SYNC_WAIT;
            cnt_d   = '0;
            sat_d   = 1'b0;
            gcnt_d  = '0;
        end else begin
            case (state_q)
                SYNC_WAIT: begin
                    if (pps_edge) begin
                        state_d = GATE;
                        cnt_d   = CNT_ONE;
                        sat_d   = 1'b0;
                        gcnt_d  = '0;
                        len_d   = gate_len;
                    end
                end
                GATE: begin
                    if (cnt_q == CNT_MAX) sat_d = 1'b1;
                    else                  cnt_d = cnt_q + CNT_ONE;
                    if (pps_edge) begin
                        if (gcnt_q != len_q) begin
                            gcnt_d = gcnt_q + GATE_W'(1);
                        end else begin
                            // Back-to-back restart: this edge opens the next gate.
                            new_res = 1'b1;
                            cnt_d   = CNT_ONE;
                            sat_d   = 1'b0;
                            gcnt_d  = '0;
                            len_d   = gate_len;
                        end
                    end else if (timeout) begin
                        state_d = SYNC_WAIT;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                        gcnt_d  = '0;
                    end
                end
                default: state_d = SYNC_WAIT;
            endcase
        end
    end

    always_comb begin
        rcnt_d   = rcnt_q;
        rgates_d = rgates_q;
        rsat_d   = rsat_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        if (new_res) begin
            rcnt_d   = cnt_q;
            rgates_d = len_q;
            rsat_d   = sat_q | (cnt_q == CNT_MAX);
            valid_d  = 1'b1;
            ovr_d    = valid_q & ~result_ack;
        end else if (result_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge system_clk) begin
        if (!system_rst_n) begin
            state_q  <= SYNC_WAIT;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            gcnt_q   <= '0;
            len_q    <= '0;
            rcnt_q   <= '0;
            rgates_q <= '0;
            rsat_q   <= 1'b0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            gcnt_q   <= gcnt_d;
            len_q    <= len_d;
            rcnt_q   <= rcnt_d;
            rgates_q <= rgates_d;
            rsat_q   <= rsat_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign result_count     = rcnt_q;
    assign result_gates     = rgates_q;
    assign result_saturated = rsat_q;
    assign result_valid     = valid_q;
    assign result_overrun   = ovr_q;

endmodule

// File: tb/tb_gps_gate_counter.sv
// Directed bench for gps_gate_counter: 32-bit and 8-bit instances share stimulus.
module tb_gps_gate_counter;

`ifdef PPS_WATCHDOG_EN
    localparam logic WD = 1'b1;
`else
    localparam logic WD = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        pps   = 1'b0;
    logic        en    = 1'b0;
    logic        ack   = 1'b0;
    logic [4:0]  glen  = '0;

    logic [31:0] c0;
    logic [7:0]  c8;
    logic [4:0]  g0, g8;
    logic        s0, s8, v0, v8, o0, o8, l0, l8, e0, e8;

    int n_chk  = 0;
    int n_fail = 0;
    int period = 0;
    int ph     = 0;

    always #5 clk = ~clk;

    gps_gate_counter #(
        .CNT_W(32), .GATE_W(5), .SYNC_STAGES(2), .TIMEOUT_CYCLES(2000)
    ) u0 (
        .system_clk(clk), .system_rst_n(rst_n), .pps_in(pps),
        .enable(en), .gate_len(glen), .result_count(c0),
        .result_gates(g0), .result_saturated(s0), .result_valid(v0),
        .result_ack(ack), .result_overrun(o0), .pps_lost(l0),
        .pps_edge(e0)
    );

    gps_gate_counter #(
        .CNT_W(8), .GATE_W(5), .SYNC_STAGES(2), .TIMEOUT_CYCLES(2000)
    ) u8 (
        .system_clk(clk), .system_rst_n(rst_n), .pps_in(pps),
        .enable(en), .gate_len(glen), .result_count(c8),
        .result_gates(g8), .result_saturated(s8), .result_valid(v8),
        .result_ack(ack), .result_overrun(o8), .pps_lost(l8),
        .pps_edge(e8)
    );

    // PPS source: rising edges exactly `period` cycles apart, 10-cycle pulse.
    initial forever begin
        @(negedge clk);
        if (period == 0) begin
            pps = 1'b0;
            ph  = 0;
        end else begin
            pps = (ph < 10);
            ph  = (ph >= period - 1) ? 0 : ph + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int lim);
        int k = 0;
        while (!v0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(v0), 64'd1);
    endtask

    task automatic wait_edge(input string tag, input int lim);
        int k = 0;
        while (!e0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(e0), 64'd1);
    endtask

    task automatic do_ack;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        cyc(3);
        chk("rst_cnt", 64'(c0), 64'd0);
        chk("rst_gates", 64'(g0), 64'd0);
        chk("rst_sat", 64'(s0), 64'd0);
        chk("rst_valid", 64'(v0), 64'd0);
        chk("rst_ovr", 64'(o0), 64'd0);
        chk("rst_lost", 64'(l0), 64'd0);
        chk("rst_edge", 64'(e0), 64'd0);
        rst_n = 1'b1;

        // gate_len=0, 1000-cycle period
        glen   = 5'd0;
        period = 1000;
        en     = 1'b1;
        wait_valid("t1_to", 2500);
        chk("t1_cnt", 64'(c0), 64'd1000);
        chk("t1_gates", 64'(g0), 64'd0);
        chk("t1_sat", 64'(s0), 64'd0);
        chk("t1_ovr", 64'(o0), 64'd0);
        chk("t1_c8", 64'(c8), 64'd255);
        chk("t1_s8", 64'(s8), 64'd1);
        do_ack;
        chk("t1_ackv", 64'(v0), 64'd0);

        // gate_len change mid-gate only applies from the next gate
        glen = 5'd3;
        wait_valid("t1b_to", 1500);
        chk("t1b_cnt", 64'(c0), 64'd1000);
        chk("t1b_gates", 64'(g0), 64'd0);
        do_ack;
        wait_valid("t1c_to", 4500);
        chk("t1c_cnt", 64'(c0), 64'd4000);
        chk("t1c_gates", 64'(g0), 64'd3);
        do_ack;

        // gate_len=3, 500-cycle period
        en = 1'b0;
        cyc(2);
        period = 500;
        cyc(2);
        en = 1'b1;
        wait_valid("t2_to", 2600);
        chk("t2_cnt", 64'(c0), 64'd2000);
        chk("t2_gates", 64'(g0), 64'd3);
        chk("t2_sat", 64'(s0), 64'd0);
        do_ack;

        // 8-bit saturation, then a short gate proves the restart from 1
        en = 1'b0;
        glen = 5'd0;
        cyc(2);
        period = 300;
        cyc(2);
        en = 1'b1;
        wait_valid("t3_to", 700);
        chk("t3_c8", 64'(c8), 64'd255);
        chk("t3_s8", 64'(s8), 64'd1);
        chk("t3_c0", 64'(c0), 64'd300);
        do_ack;
        period = 200;
        wait_valid("t3b_to", 300);
        chk("t3b_c8", 64'(c8), 64'd200);
        chk("t3b_s8", 64'(s8), 64'd0);
        chk("t3b_c0", 64'(c0), 64'd200);
        do_ack;

        // overrun when unacked, cleared by ack
        wait_valid("t4_to", 300);
        wait_edge("t4_e", 300);
        cyc(1);
        chk("t4_ovr", 64'(o0), 64'd1);
        chk("t4_valid", 64'(v0), 64'd1);
        chk("t4_cnt", 64'(c0), 64'd200);
        do_ack;
        chk("t4_ackv", 64'(v0), 64'd0);
        chk("t4_acko", 64'(o0), 64'd0);

        // ack coinciding with the new result
        wait_valid("t4b_to", 300);
        wait_edge("t4b_e", 300);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        chk("t4b_valid", 64'(v0), 64'd1);
        chk("t4b_ovr", 64'(o0), 64'd0);
        chk("t4b_cnt", 64'(c0), 64'd200);

        // reset mid-gate clears held result and discards the gate
        cyc(100);
        rst_n = 1'b0;
        cyc(2);
        chk("t6_rst_v", 64'(v0), 64'd0);
        chk("t6_rst_c", 64'(c0), 64'd0);
        rst_n = 1'b1;
        wait_edge("t6_e1", 300);
        cyc(3);
        chk("t6_nores", 64'(v0), 64'd0);
        wait_valid("t6_to", 300);
        chk("t6_cnt", 64'(c0), 64'd200);

        // enable=0 mid-gate keeps the held result
        cyc(100);
        en = 1'b0;
        wait_edge("t6_e2", 300);
        cyc(3);
        chk("t6_hold_v", 64'(v0), 64'd1);
        chk("t6_hold_c", 64'(c0), 64'd200);
        chk("t6_hold_o", 64'(o0), 64'd0);
        en = 1'b1;
        wait_edge("t6_e3", 300);
        cyc(1);
        wait_edge("t6_e4", 300);
        cyc(1);
        chk("t6_ovr", 64'(o0), 64'd1);
        chk("t6_cnt2", 64'(c0), 64'd200);
        do_ack;

        // PPS stops mid-gate
        period = 0;
        cyc(1900);
        chk("t5_early", 64'(l0), 64'd0);
        cyc(200);
        chk("t5_lost", 64'(l0), 64'(WD));
        chk("t5_nores", 64'(v0), 64'd0);
        if (!WD) begin
            en = 1'b0;
            cyc(2);
            en = 1'b1;
        end
        period = 200;
        wait_edge("t5_e", 50);
        cyc(1);
        chk("t5_clr", 64'(l0), 64'd0);
        wait_valid("t5_to", 300);
        chk("t5_cnt", 64'(c0), 64'd200);
        do_ack;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
